mul_share_arbiter: RTL and testbench

- Shares one pipelined array multiplier among NUM_REQ requesters.
- Round-robin arbitration on a valid/ready request interface; registered issue of operands to the multiplier.
- Tracks each in-flight operation's requester ID through a tag pipeline aligned with the multiplier latency, and routes each product back to its requester.
- Includes a drain/quiesce controller so software/top level can stop new issue and wait for the pipeline to empty.

---
 rtl/mul_share_arbiter.sv | 92 +++++++++
 tb/tb_mul_share_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one pipelined multiplier, with tag routing and drain control.
// Define MUL_ARB_ALIGN_CHECK_EN to add the sticky align_err output that masks responses.
module mul_share_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATAWIDTH   = 16,
    parameter int MUL_LATENCY = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   req_A,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   req_B,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [2*DATAWIDTH-1:0]         rsp_Z,
    input  logic                           drain_req,
    output logic                           idle,
    output logic                           mul_i_valid,
    output logic [DATAWIDTH-1:0]           mul_A,
    output logic [DATAWIDTH-1:0]           mul_B,
    input  logic                           mul_o_valid,
    input  logic [2*DATAWIDTH-1:0]         mul_Z
`ifdef MUL_ARB_ALIGN_CHECK_EN
    ,
    output logic                           align_err
`endif
);
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {RUN, DRAIN, IDLE} state_t;
    state_t state, state_nxt;
    logic [IW-1:0] rr_ptr, gnt_id;
    logic gnt_hit, accept, pipe_empty, rsp_ok;
    logic [MUL_LATENCY:0] tag_v;
    logic [IW-1:0] tag_id [MUL_LATENCY+1];
    logic [NUM_REQ-1:0] rsp_q;
    // Walk offsets high to low so the closest requester above rr_ptr wins; ready is held low during reset.
    always_comb begin
        gnt_id = rr_ptr;
        gnt_hit = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                gnt_hit = 1'b1;
                gnt_id = IW'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
        req_ready = (rst && state == RUN && !drain_req && gnt_hit) ? NUM_REQ'(1) << gnt_id : '0;
    end
    assign accept = |(req_valid & req_ready);
    assign mul_i_valid = tag_v[0];
    always_comb begin
        pipe_empty = !(|tag_v) && !(|rsp_q);
        state_nxt = !drain_req ? RUN : (state == RUN) ? DRAIN : (state == DRAIN && pipe_empty) ? IDLE : state;
        idle = state == IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            rr_ptr <= '0;
            tag_v <= '0;
            mul_A <= '0;
            mul_B <= '0;
            rsp_q <= '0;
            rsp_Z <= '0;
            for (int k = 0; k <= MUL_LATENCY; k++) tag_id[k] <= '0;
        end else begin
            state <= state_nxt;
            tag_v <= {tag_v[MUL_LATENCY-1:0], accept};
            tag_id[0] <= gnt_id;
            for (int k = 1; k <= MUL_LATENCY; k++) tag_id[k] <= tag_id[k-1];
            if (accept) begin
                rr_ptr <= (gnt_id == IW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
                mul_A <= req_A[int'(gnt_id) * DATAWIDTH +: DATAWIDTH];
                mul_B <= req_B[int'(gnt_id) * DATAWIDTH +: DATAWIDTH];
            end
            rsp_q <= rsp_ok ? NUM_REQ'(1) << tag_id[MUL_LATENCY] : '0;
            if (mul_o_valid) rsp_Z <= mul_Z;
        end
    end
`ifdef MUL_ARB_ALIGN_CHECK_EN
    logic mismatch;
    assign mismatch = mul_o_valid != tag_v[MUL_LATENCY];
    assign rsp_ok = mul_o_valid && !mismatch && !align_err;
    assign rsp_valid = align_err ? '0 : rsp_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) align_err <= 1'b0;
        else if (mismatch) align_err <= 1'b1;
    end
`else
    assign rsp_ok = mul_o_valid;
    assign rsp_valid = rsp_q;
`endif
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: directed table, corner sequences and random traffic against a queue-based reference model.
module tb_mul_share_arbiter;
    localparam int NR = 4, DW = 16, L = 2;
    logic clk = 1'b0, rst = 1'b0, drain_req = 1'b0, idle, mul_i_valid, mul_o_valid;
    logic [NR-1:0] req_valid = '0, req_ready, rsp_valid;
    logic [NR*DW-1:0] req_A = '0, req_B = '0;
    logic [2*DW-1:0] rsp_Z, mul_Z;
    logic [DW-1:0] mul_A, mul_B;
`ifdef MUL_ARB_ALIGN_CHECK_EN
    logic align_err;
`endif
    int n_chk = 0, n_fail = 0, cyc = 0, mrr = 0, m_g;
    bit mon_en = 1'b1, force_ov = 1'b0, prev_drain = 1'b0;
    logic [NR-1:0] m_er, m_ev;
    logic [2*DW-1:0] m_ez;
    typedef struct { int id; logic [2*DW-1:0] z; int due; } rsp_t;
    rsp_t q[$];
    typedef struct { logic [NR-1:0] rv; logic [NR*DW-1:0] a, b; logic [NR-1:0] rdy; logic [2*DW-1:0] z; } vec_t;
    logic [L-1:0] pv;
    logic [2*DW-1:0] pz [L];

    mul_share_arbiter #(.NUM_REQ(NR), .DATAWIDTH(DW), .MUL_LATENCY(L)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_A(req_A), .req_B(req_B), .rsp_valid(rsp_valid), .rsp_Z(rsp_Z),
        .drain_req(drain_req), .idle(idle), .mul_i_valid(mul_i_valid),
        .mul_A(mul_A), .mul_B(mul_B), .mul_o_valid(mul_o_valid), .mul_Z(mul_Z)
`ifdef MUL_ARB_ALIGN_CHECK_EN
        , .align_err(align_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pipelined multiplier of depth L, reset together with the arbiter.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pv <= '0;
            for (int i = 0; i < L; i++) pz[i] <= '0;
        end else begin
            pv[0] <= mul_i_valid;
            pz[0] <= (2*DW)'(mul_A) * (2*DW)'(mul_B);
            for (int i = 1; i < L; i++) begin
                pv[i] <= pv[i-1];
                pz[i] <= pz[i-1];
            end
        end
    end
    assign mul_o_valid = pv[L-1] | force_ov;
    assign mul_Z = pz[L-1];

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    function automatic logic [NR*DW-1:0] pk(int i, logic [DW-1:0] v, logic [DW-1:0] junk);
        logic [NR*DW-1:0] r = {NR{junk}};
        r[i*DW +: DW] = v;
        return r;
    endfunction

    // Reference: grants allowed only when drain_req is low now and was low last cycle;
    // each accepted op yields its product on the owner L+2 cycles later.
    always @(negedge clk) begin
        if (!rst) begin
            mrr = 0;
            prev_drain = 1'b0;
            q.delete();
        end else if (mon_en) begin
            m_er = '0;
            m_g = -1;
            if (!drain_req && !prev_drain)
                for (int k = 0; k < NR; k++)
                    if (m_g < 0 && req_valid[(mrr + k) % NR]) m_g = (mrr + k) % NR;
            if (m_g >= 0) m_er = NR'(1) << m_g;
            chk("grant", req_ready, m_er);
            if (m_g >= 0) begin
                q.push_back('{m_g, (2*DW)'(req_A[m_g*DW +: DW]) * (2*DW)'(req_B[m_g*DW +: DW]), cyc + L + 2});
                mrr = (m_g + 1) % NR;
            end
            prev_drain = drain_req;
            m_ev = '0;
            m_ez = '0;
            if (q.size() > 0 && q[0].due == cyc) begin
                m_ev = NR'(1) << q[0].id;
                m_ez = q[0].z;
                void'(q.pop_front());
            end
            chk("rsp_valid", rsp_valid, m_ev);
            if (m_ev != 0) chk("rsp_Z", rsp_Z, m_ez);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time bound exceeded at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [6];
        int w, r;
        tbl[0] = '{4'b0010, pk(1, 16'h0003, 16'h5A5A), pk(1, 16'h0005, 16'hA5A5), 4'b0010, 32'h0000000F};
        tbl[1] = '{4'b1000, pk(3, 16'hFFFF, 16'h5A5A), pk(3, 16'hFFFF, 16'hA5A5), 4'b1000, 32'hFFFE0001};
        tbl[2] = '{4'b1111, pk(0, 16'h0007, 16'h5A5A), pk(0, 16'h0009, 16'hA5A5), 4'b0001, 32'h0000003F};
        tbl[3] = '{4'b0101, pk(2, 16'h1234, 16'h5A5A), pk(2, 16'h0000, 16'hA5A5), 4'b0100, 32'h00000000};
        tbl[4] = '{4'b0011, pk(0, 16'h8000, 16'h5A5A), pk(0, 16'h0002, 16'hA5A5), 4'b0001, 32'h00010000};
        tbl[5] = '{4'b1001, pk(3, 16'hABCD, 16'h5A5A), pk(3, 16'h0100, 16'hA5A5), 4'b1000, 32'h00ABCD00};
        mid();
        chk("reset_outputs", {req_ready, rsp_valid, rsp_Z, mul_i_valid, mul_A, mul_B, idle}, '0);
        tick();
        rst = 1'b1;
        mid();
        chk("idle_after_reset", idle, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            req_valid = tbl[i].rv;
            req_A = tbl[i].a;
            req_B = tbl[i].b;
            mid();
            chk("tbl_ready", req_ready, tbl[i].rdy);
            tick();
            req_valid = '0;
            for (int k = 1; k <= L + 2; k++) begin
                mid();
                chk("tbl_rsp_valid", rsp_valid, (k == L + 2) ? tbl[i].rdy : '0);
                if (k == L + 2) chk("tbl_rsp_Z", rsp_Z, tbl[i].z);
                if (k < L + 2) tick();
            end
        end
        for (int i = 0; i < NR; i++) begin
            req_A[i*DW +: DW] = DW'(i + 1);
            req_B[i*DW +: DW] = 16'h0010;
        end
        for (int k = 0; k < 8 + L + 2; k++) begin
            tick();
            req_valid = (k < 8) ? '1 : '0;
            mid();
            if (k < 8) chk("rot_grant", req_ready, NR'(1) << (k % NR));
            if (k >= L + 2) begin
                chk("rot_rsp_valid", rsp_valid, NR'(1) << ((k - L - 2) % NR));
                chk("rot_rsp_Z", rsp_Z, 32'((((k - L - 2) % NR) + 1) * 16));
            end
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            req_valid = 4'b0100;
            mid();
            chk("single_grant", req_ready, 4'b0100);
        end
        tick();
        req_valid = '0;
        repeat (L + 3) tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            req_valid = '1;
            req_A = {$urandom, $urandom};
            req_B = {$urandom, $urandom};
        end
        tick();
        drain_req = 1'b1;
        mid();
        chk("drain_gate", req_ready, '0);
        w = 0;
        while (!idle && w < 20) begin
            tick();
            mid();
            w++;
        end
        chk("drain_idle", idle, 1);
        chk("drain_flush", q.size(), 0);
        chk("drain_mul_iv", mul_i_valid, 0);
        tick();
        drain_req = 1'b0;
        mid();
        r = mrr;
        chk("idle_hold", idle, 1);
        chk("release_gate", req_ready, '0);
        tick();
        mid();
        chk("idle_fall", idle, 0);
        chk("resume_rr", req_ready, NR'(1) << r);
        tick();
        req_valid = 4'b0011;
        mid();
        tick();
        mid();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_outputs", {req_ready, rsp_valid, rsp_Z, mul_i_valid, mul_A, mul_B, idle}, '0);
        tick();
        req_valid = '0;
        tick();
        rst = 1'b1;
        for (int k = 0; k < L + 4; k++) begin
            mid();
            chk("no_stale_rsp", rsp_valid, '0);
            tick();
        end
        req_valid = '1;
        mid();
        chk("rst_first_grant", req_ready, 4'b0001);
        for (int k = 0; k < 400; k++) begin
            tick();
            req_valid = NR'($urandom);
            req_A = {$urandom, $urandom};
            req_B = {$urandom, $urandom};
            if ($urandom_range(0, 19) == 0) drain_req = !drain_req;
        end
        tick();
        req_valid = '0;
        drain_req = 1'b0;
        repeat (L + 4) tick();
        mid();
        chk("rand_flush", q.size(), 0);
`ifdef MUL_ARB_ALIGN_CHECK_EN
        mon_en = 1'b0;
        tick();
        force_ov = 1'b1;
        mid();
        chk("align_pre", align_err, 0);
        tick();
        force_ov = 1'b0;
        mid();
        chk("align_set", align_err, 1);
        chk("align_rsp", rsp_valid, '0);
        tick();
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        for (int k = 0; k < L + 4; k++) begin
            mid();
            chk("align_sticky", align_err, 1);
            chk("align_mask", rsp_valid, '0);
            tick();
        end
        rst = 1'b0;
        #1;
        chk("align_rst", align_err, 0);
        tick();
        rst = 1'b1;
        mon_en = 1'b1;
`endif
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
